// File: rtl/audio_dma_reader.sv
// Audio DMA reader: fetches bytes from memory over a simple req/gnt bus
// and plays each one as two 4-bit samples (high nibble first) on the
// left/right outputs, each nibble lasting (RATE_BASE << rate) ce_ticks.
module audio_dma_reader #(
    parameter int RATE_BASE = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_tick,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_length,
    input  logic [7:0]  dma_ctrl,
    input  logic        trig_wr,
    input  logic [7:0]  trig_data,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    output logic [2:0]  rom_bank,
    output logic [3:0]  left,
    output logic [3:0]  right,
    output logic        busy,
    output logic        done
);
    // Period counter must reach (RATE_BASE << 3) - 1.
    localparam int PW = $clog2(RATE_BASE) + 4;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY_HI, PLAY_LO} state_t;

    state_t        state, state_next;
    logic [15:0]   addr_q;
    logic [12:0]   count_q;      // bytes still to play, 1..4096
    logic [1:0]    rate_q;
    logic          left_en_q;
    logic          right_en_q;
    logic [2:0]    bank_q;
    logic [7:0]    sample_q;
    logic [PW-1:0] period_cnt;
    logic [PW-1:0] period_last;
    logic          period_end;
    logic          start;
    logic [3:0]    nibble;
    logic          unused_bits;

    // Register bits with no function in this block.
    assign unused_bits = ^{dma_ctrl[7], trig_data[6:0]};

    assign start       = trig_wr && trig_data[7];
    assign period_last = PW'((RATE_BASE << rate_q) - 1);
    assign period_end  = ce_tick && (period_cnt == period_last);
    assign nibble      = (state == PLAY_HI) ? sample_q[7:4] : sample_q[3:0];
    assign bus_addr    = addr_q;
    assign rom_bank    = bank_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked blocks use <= so every register sees pre-edge values.
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic and state-decoded bus/status outputs.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latch).
        state_next = state;
        bus_req    = (state == FETCH);
        busy       = (state != IDLE);
        case (state)
            IDLE:    state_next = IDLE;
            FETCH:   if (bus_gnt) state_next = WAIT;
            WAIT:    state_next = PLAY_HI;
            PLAY_HI: if (period_end) state_next = PLAY_LO;
            PLAY_LO: if (period_end) state_next = (count_q == 13'd1) ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
        // A CPU trigger overrides the sequencer, including a same-cycle grant.
        if (trig_wr) state_next = trig_data[7] ? FETCH : IDLE;
    end

    // Transfer registers: latched on start, stepped as nibbles complete.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q     <= '0;
            count_q    <= '0;
            rate_q     <= '0;
            left_en_q  <= 1'b0;
            right_en_q <= 1'b0;
            bank_q     <= '0;
            period_cnt <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                addr_q     <= dma_addr;
                count_q    <= (dma_length == 8'd0) ? 13'd4096 : {1'b0, dma_length, 4'b0000};
                rate_q     <= dma_ctrl[1:0];
                right_en_q <= dma_ctrl[2];
                left_en_q  <= dma_ctrl[3];
                bank_q     <= dma_ctrl[6:4];
                period_cnt <= '0;
            end else if (!trig_wr) begin
                case (state)
                    WAIT: period_cnt <= '0;
                    PLAY_HI: begin
                        if (ce_tick) period_cnt <= period_end ? '0 : period_cnt + 1'b1;
                    end
                    PLAY_LO: begin
                        if (period_end) begin
                            period_cnt <= '0;
                            addr_q     <= addr_q + 16'd1;
                            count_q    <= count_q - 13'd1;
                            done       <= (count_q == 13'd1);
                        end else if (ce_tick) begin
                            period_cnt <= period_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sample byte captured in WAIT, the cycle after the grant.
    always_ff @(posedge clk) begin
        // NOTE: data-only register, deliberately not reset; it is read only after WAIT loads it.
        if (reset_n && !trig_wr && state == WAIT) sample_q <= bus_din;
    end

    // Channel outputs: show the current nibble one cycle after the play state
    // is entered, hold across the refetch, and clear when idle or retriggered.
    always_ff @(posedge clk) begin
        if (!reset_n || trig_wr || state == IDLE) begin
            left  <= 4'h0;
            right <= 4'h0;
        end else if (state == PLAY_HI || state == PLAY_LO) begin
            left  <= left_en_q  ? nibble : 4'h0;
            right <= right_en_q ? nibble : 4'h0;
        end
    end

endmodule

// File: tb/tb_audio_dma_reader.sv
// Self-checking bench for audio_dma_reader: directed scenarios plus a
// randomized phase, all compared against a transfer-level reference model.
module tb_audio_dma_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_tick = 1'b0;
    logic [15:0] dma_addr;
    logic [7:0]  dma_length;
    logic [7:0]  dma_ctrl;
    logic        trig_wr;
    logic [7:0]  trig_data;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din = 8'h00;
    logic [2:0]  rom_bank;
    logic [3:0]  left, right;
    logic        busy, done;

    always #5 clk = ~clk;

    audio_dma_reader #(.RATE_BASE(256)) dut (
        .clk(clk), .reset_n(reset_n), .ce_tick(ce_tick),
        .dma_addr(dma_addr), .dma_length(dma_length), .dma_ctrl(dma_ctrl),
        .trig_wr(trig_wr), .trig_data(trig_data),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_din(bus_din),
        .rom_bank(rom_bank), .left(left), .right(right), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory image, bus responder and ce_tick source.
    logic [7:0]  mem [0:65535];
    int          gnt_mode = 0;   // 0 grant at once, 1 random grant, 2 never grant
    int          ce_mode  = 0;   // 0 no ticks, 1 tick every cycle, 2 random ticks
    logic        data_due = 1'b0;
    logic [15:0] due_addr = '0;
    logic [15:0] fetch_q[$];
    int          done_cnt = 0;
    bit          chk_en = 0;

    always @(negedge clk) begin
        bus_din  = data_due ? mem[due_addr] : 8'($urandom);
        data_due = 1'b0;
        case (gnt_mode)
            0:       bus_gnt = (bus_req === 1'b1);
            1:       bus_gnt = ($urandom_range(0, 2) == 0);
            default: bus_gnt = 1'b0;
        endcase
        if (bus_gnt && bus_req === 1'b1) begin
            data_due = 1'b1;
            due_addr = bus_addr;
            fetch_q.push_back(bus_addr);
        end
        case (ce_mode)
            1:       ce_tick = 1'b1;
            2:       ce_tick = 1'($urandom_range(0, 1));
            default: ce_tick = 1'b0;
        endcase
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Reference model: a transfer is a list of bytes base..base+total-1, each
    // played as hi then lo nibble for 'period' ticks, with a fetch+data cycle
    // before each byte. Outputs lag the sequence position by one clock.
    bit          m_on = 0, m_fetch = 0, m_data = 0, m_half = 0;
    bit          m_len = 0, m_ren = 0;
    int          m_idx = 0, m_total = 0, m_ticks = 0, m_period = 0;
    logic [15:0] m_base = '0;
    logic [2:0]  m_bank = '0;
    logic [7:0]  m_byte = '0;
    logic [3:0]  exp_left = '0, exp_right = '0;
    bit          exp_done = 0;

    always @(posedge clk) begin : model
        bit         playing;
        logic [3:0] nib;
        playing  = m_on && !m_fetch && !m_data;
        nib      = m_half ? m_byte[3:0] : m_byte[7:4];
        exp_done = 0;
        if (!reset_n) begin
            m_on = 0; m_fetch = 0; m_data = 0; m_bank = '0;
            exp_left = '0; exp_right = '0;
        end else begin
            if (trig_wr || !m_on) begin
                exp_left = '0; exp_right = '0;
            end else if (playing) begin
                exp_left  = m_len ? nib : 4'h0;
                exp_right = m_ren ? nib : 4'h0;
            end
            if (trig_wr) begin
                if (trig_data[7]) begin
                    m_on = 1; m_fetch = 1; m_data = 0; m_idx = 0;
                    m_base   = dma_addr;
                    m_total  = ((dma_length == 0) ? 256 : int'(dma_length)) * 16;
                    m_period = 256 * (1 << dma_ctrl[1:0]);
                    m_ren    = dma_ctrl[2];
                    m_len    = dma_ctrl[3];
                    m_bank   = dma_ctrl[6:4];
                end else begin
                    m_on = 0;
                end
            end else if (m_on) begin
                if (m_fetch) begin
                    if (bus_gnt) begin m_fetch = 0; m_data = 1; end
                end else if (m_data) begin
                    m_data = 0; m_half = 0; m_ticks = 0;
                    m_byte = mem[16'(m_base + 16'(m_idx))];
                end else if (ce_tick) begin
                    m_ticks++;
                    if (m_ticks == m_period) begin
                        m_ticks = 0;
                        if (!m_half) m_half = 1;
                        else begin
                            m_idx++;
                            if (m_idx == m_total) begin m_on = 0; exp_done = 1; end
                            else m_fetch = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_on);
            check("bus_req", bus_req, m_on && m_fetch);
            if (m_on && m_fetch) check("bus_addr", bus_addr, 16'(m_base + 16'(m_idx)));
            check("done", done, exp_done);
            check("left", left, exp_left);
            check("right", right, exp_right);
            check("rom_bank", rom_bank, m_bank);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic trigger(input logic [7:0] d);
        @(negedge clk); trig_wr = 1'b1; trig_data = d;
        @(negedge clk); trig_wr = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1; break; end
        end
    endtask

    task automatic wait_left(input logic [3:0] v, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (left === v) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, held, lnz;
        int d0, run;
        reset_n = 1'b0; trig_wr = 1'b0; trig_data = '0;
        dma_addr = '0; dma_length = '0; dma_ctrl = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        cycles(3);
        check("rst_busy", busy, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_done", done, 0);
        check("rst_lr", {left, right}, 0);
        check("rst_bank", rom_bank, 0);
        chk_en = 1;
        reset_n = 1'b1;
        cycles(2);

        // Scenario 1: 16 bytes 0x00..0x0F at 0x8000, both channels, rate 0.
        ce_mode = 1; gnt_mode = 0;
        for (int i = 0; i < 16; i++) mem[16'h8000 + i] = 8'(i);
        dma_addr = 16'h8000; dma_length = 8'd1; dma_ctrl = 8'h0C;
        fetch_q.delete(); d0 = done_cnt;
        trigger(8'h80);
        dma_addr = 16'h1111; dma_length = 8'd9; dma_ctrl = 8'h73;
        wait_idle(12000, ok);
        check("s1_finished", ok, 1);
        cycles(4);
        check("s1_done_pulses", done_cnt - d0, 1);
        check("s1_fetch_count", fetch_q.size(), 16);
        for (int i = 0; i < 16; i++)
            check("s1_fetch_addr", (i < fetch_q.size()) ? 32'(fetch_q[i]) : 32'hDEAD, 32'h8000 + i);

        // Stop trigger while idle has no effect.
        d0 = done_cnt;
        trigger(8'h00);
        cycles(3);
        check("idle_stop_busy", busy, 0);
        check("idle_stop_done", done_cnt - d0, 0);

        // Scenario 2: rate 3, right only, byte 0xA5.
        mem[16'h1234] = 8'hA5; mem[16'h1235] = 8'h3C;
        dma_addr = 16'h1234; dma_length = 8'd1; dma_ctrl = 8'h07;
        trigger(8'h80);
        run = 0; lnz = 0;
        for (int i = 0; i < 20 && right !== 4'hA; i++) @(negedge clk);
        check("s2_hi_seen", right, 4'hA);
        while (right === 4'hA && run < 5000) begin
            if (left !== 4'h0) lnz = 1;
            @(negedge clk); run++;
        end
        check("s2_hi_cycles", run, 2048);
        check("s2_lo_seen", right, 4'h5);
        run = 0;
        while (right === 4'h5 && run < 5000) begin
            if (left !== 4'h0) lnz = 1;
            @(negedge clk); run++;
        end
        // Low nibble holds through the fetch and data cycles of the next byte.
        check("s2_lo_cycles", run, 2050);
        check("s2_left_zero", lnz, 0);
        trigger(8'h00);

        // Scenario 3: address wrap and rom_bank, random ticks.
        ce_mode = 2;
        dma_addr = 16'hFFFF; dma_length = 8'd1; dma_ctrl = 8'h5C;
        fetch_q.delete();
        trigger(8'h80);
        dma_ctrl = 8'h2C;
        for (int i = 0; i < 6000 && fetch_q.size() < 2; i++) @(negedge clk);
        check("s3_fetch0", (fetch_q.size() > 0) ? 32'(fetch_q[0]) : 32'hDEAD, 32'hFFFF);
        check("s3_fetch1", (fetch_q.size() > 1) ? 32'(fetch_q[1]) : 32'hDEAD, 32'h0000);
        check("s3_bank", rom_bank, 3'd5);
        trigger(8'h00);

        // Scenario 4: stop mid PLAY_HI, then restart from a new address.
        ce_mode = 1;
        mem[16'h2000] = 8'h9B; mem[16'h3000] = 8'hC4;
        dma_addr = 16'h2000; dma_length = 8'd2; dma_ctrl = 8'h0C;
        trigger(8'h80);
        wait_left(4'h9, 20, ok);
        check("s4_hi_seen", ok, 1);
        cycles(100);
        d0 = done_cnt;
        trigger(8'h00);
        check("s4_stop_busy", busy, 0);
        check("s4_stop_lr", {left, right}, 0);
        check("s4_stop_req", bus_req, 0);
        cycles(10);
        check("s4_no_done", done_cnt - d0, 0);
        dma_addr = 16'h3000; fetch_q.delete();
        trigger(8'h80);
        cycles(2);
        check("s4_restart_addr", (fetch_q.size() > 0) ? 32'(fetch_q[0]) : 32'hDEAD, 32'h3000);
        wait_left(4'hC, 20, ok);
        check("s4_restart_data", ok, 1);
        trigger(8'h00);

        // Scenario 5: grant withheld for 50 cycles.
        gnt_mode = 2;
        mem[16'h4000] = 8'h6D;
        dma_addr = 16'h4000; dma_ctrl = 8'h0C;
        trigger(8'h80);
        held = 1;
        for (int i = 0; i < 50; i++) begin
            if (bus_req !== 1'b1 || bus_addr !== 16'h4000 || left !== 4'h0) held = 0;
            @(negedge clk);
        end
        check("s5_req_held", held, 1);
        gnt_mode = 0;
        wait_left(4'h6, 20, ok);
        check("s5_resume", ok, 1);
        trigger(8'h00);

        // Scenario 6: reset while read data is in flight.
        dma_addr = 16'h5000; dma_ctrl = 8'h3C;
        trigger(8'h80);
        @(negedge clk);
        check("s6_in_wait", {busy, bus_req}, 2'b10);
        reset_n = 1'b0;
        @(negedge clk);
        check("s6_rst_outputs", {busy, bus_req, done, left, right, rom_bank}, 0);
        reset_n = 1'b1;
        dma_addr = 16'h6000; fetch_q.delete();
        trigger(8'h80);
        cycles(2);
        check("s6_new_addr", (fetch_q.size() > 0) ? 32'(fetch_q[0]) : 32'hDEAD, 32'h6000);
        trigger(8'h00);

        // Restart trigger coinciding with a grant: the granted read is dropped.
        mem[16'h7000] = 8'hE1;
        dma_addr = 16'h6100; dma_ctrl = 8'h0C;
        @(negedge clk); trig_wr = 1'b1; trig_data = 8'h80;
        @(negedge clk); dma_addr = 16'h7000;
        @(negedge clk); trig_wr = 1'b0;
        wait_left(4'hE, 20, ok);
        check("gnt_trig_priority", ok, 1);
        trigger(8'h00);

        // Randomized phase: random grants, ticks, register writes and triggers.
        gnt_mode = 1; ce_mode = 2;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            dma_addr   = 16'($urandom);
            dma_length = 8'($urandom);
            dma_ctrl   = 8'($urandom);
            trig_wr    = ($urandom_range(0, 399) == 0);
            trig_data  = {($urandom_range(0, 3) != 0), 7'($urandom)};
        end
        @(negedge clk); trig_wr = 1'b0;
        cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_dma_reader.md
AUDIO_DMA_READER -- requirements
Module: audio_dma_reader

Interface
REQ-001 Parameter: RATE_BASE, default 256, ce_tick count per nibble at rate code 0.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 ce_tick  in  1  sample-rate clock enable; one-cycle pulse.
REQ-005 dma_addr  in  16  start address (audio DMA address register).
REQ-006 dma_length  in  8  length in 16-byte units; 0 means 256 units.
REQ-007 dma_ctrl  in  8  [1:0] rate code, [2] right enable, [3] left enable, [6:4] ROM bank.
REQ-008 trig_wr  in  1  one-cycle pulse on CPU write to the trigger register.
REQ-009 trig_data  in  8  trigger data; [7]=1 start, [7]=0 stop.
REQ-010 bus_req  out  1  memory read request.
REQ-011 bus_gnt  in  1  grant; read data valid the cycle after grant.
REQ-012 bus_addr  out  16  read address; stable while bus_req=1.
REQ-013 bus_din  in  8  read data.
REQ-014 rom_bank  out  3  latched dma_ctrl[6:4] for the active transfer.
REQ-015 left, right  out  4 each  unsigned sample nibbles.
REQ-016 busy  out  1  transfer in progress.
REQ-017 done  out  1  one-cycle pulse at normal completion.

Function
REQ-018 States: IDLE, FETCH, WAIT, PLAY_HI, PLAY_LO.
REQ-019 IDLE + trig_wr + trig_data[7]=1: latch addr, ctrl, byte count = dma_length*16 (0 -> 4096); next state FETCH; busy=1 from the next cycle.
REQ-020 FETCH: bus_req=1, bus_addr=current addr; on bus_gnt=1 go to WAIT; bus_req=0 from the next cycle.
REQ-021 WAIT: capture bus_din into the sample register; go to PLAY_HI with the period counter cleared.
REQ-022 Period: RATE_BASE << rate code ce_tick pulses per nibble (256/512/1024/2048 at default); counter advances only on ce_tick.
REQ-023 PLAY_HI: output byte[7:4]; at period end go to PLAY_LO. PLAY_LO: output byte[3:0]; at period end, addr+1 and count-1.
REQ-024 PLAY_LO end with count>1: go to FETCH; with count=1: go to IDLE, done=1 for one cycle, busy=0 the same cycle.
REQ-025 left = latched ctrl[3] ? nibble : 0; right = latched ctrl[2] ? nibble : 0; both 0 in IDLE, FETCH before the first byte, and after stop.
REQ-026 Output latency: nibble visible on left/right one cycle after the state register enters PLAY_HI/PLAY_LO.
REQ-027 Address increments modulo 2^16 (0xFFFF -> 0x0000); rom_bank stays constant during the transfer.
REQ-028 trig_wr, trig_data[7]=0, any non-IDLE state: go to IDLE next cycle, bus_req=0, outputs 0, no done.
REQ-029 trig_wr, trig_data[7]=1, non-IDLE state: restart per REQ-019 with new register values; no done for the aborted transfer.
REQ-030 A trigger arriving in FETCH with bus_gnt=1 in the same cycle takes priority; read data the next cycle is discarded.
REQ-031 trig_wr with trig_data[7]=0 in IDLE: no effect.
REQ-032 dma_addr, dma_length, dma_ctrl changes after start do not affect the active transfer.

Reset
REQ-033 reset_n=0 at a clock edge: state IDLE, counters 0, bus_req=0, busy=0, done=0, left=right=0, rom_bank=0.
REQ-034 Reset has priority over trig_wr and bus_gnt in the same cycle; an outstanding grant's data is ignored.

Verification
REQ-035 Scenario 1: addr=0x8000, length=1, ctrl=0x0C, trigger 0x80, grant immediately, bytes 0x00..0x0F -> 16 fetches at 0x8000..0x800F, 32 nibbles each lasting 256 ce_ticks on left and right, then a single done pulse, busy=0.
REQ-036 Scenario 2: ctrl=0x07 (rate 3, right only), byte 0xA5 -> right=0xA for 2048 ticks then 0x5 for 2048 ticks, left=0 throughout.
REQ-037 Scenario 3: addr=0xFFFF, length=1 -> second fetch address 0x0000; rom_bank equals ctrl[6:4] throughout.
REQ-038 Scenario 4: stop trigger (0x00) mid-PLAY_HI -> IDLE next cycle, outputs 0, no done; a following 0x80 trigger restarts from the new dma_addr.
REQ-039 Scenario 5: bus_gnt held low for 50 cycles in FETCH -> bus_req and bus_addr stable and no nibble advance; resumes correctly on grant.
REQ-040 Scenario 6: reset_n low during WAIT while data is in flight -> all outputs at reset values, and the next trigger fetches from the new start address.
